// File: rtl/logic_unit_sched_pkg.sv
// logic_unit_sched_pkg: shared constants for the logic-unit scheduler.
//   DEF_WIDTH / DEF_OPW  default operand width and opcode width
//   OP_*                 opcode encoding of the bitwise unit
//   state_e              scheduler FSM states
package logic_unit_sched_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_OPW   = 3;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_OR    = 3'd1;
    localparam logic [2:0] OP_XOR   = 3'd2;
    localparam logic [2:0] OP_XNOR  = 3'd3;
    localparam logic [2:0] OP_NAND  = 3'd4;
    localparam logic [2:0] OP_NOR   = 3'd5;
    localparam logic [2:0] OP_NOTA  = 3'd6;
    localparam logic [2:0] OP_PASSB = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/logic_unit_core.sv
// logic_unit_core: purely combinational bitwise unit.
//   op  opcode (see logic_unit_sched_pkg OP_*)
//   a,b operands
//   y   result; bit i depends only on a[i], b[i]
module logic_unit_core
    import logic_unit_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_XNOR:  y = ~(a ^ b);
            OP_NAND:  y = ~(a & b);
            OP_NOR:   y = ~(a | b);
            OP_NOTA:  y = ~a;
            OP_PASSB: y = b;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_sched.sv
// logic_unit_sched: round-robin scheduler sharing one bitwise logic unit
// between two requesters. Each accepted transaction walks IDLE -> EXEC ->
// RESP; the result is registered in EXEC and held in RESP until consumed.
//   clk, rst_n                 clock, async active-low reset
//   reqN_valid/ready/op/a/b    requester N issue channel (N = 0, 1)
//   rsp_valid/ready/id/data    tagged result channel with backpressure
//   rsp_zero                   result==0 flag (only with LOGIC_UNIT_SCHED_ZFLAG_EN)
//   busy                       high whenever not IDLE
// Optional feature macro: LOGIC_UNIT_SCHED_ZFLAG_EN
module logic_unit_sched
    import logic_unit_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OPW   = DEF_OPW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
`ifdef LOGIC_UNIT_SCHED_ZFLAG_EN
    output logic             rsp_zero,
`endif
    output logic             busy
);

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_id_q, rsp_id_d;
    logic             grant_id;
    logic [WIDTH-1:0] core_y;

    // On a tie the requester that was not served last wins; otherwise the
    // single valid requester wins (req1_valid alone selects 1).
    always_comb begin
        grant_id = req1_valid;
        if (req0_valid && req1_valid) grant_id = ~last_grant_q;
    end

    assign req0_ready = (state_q == IDLE) && req0_valid && !grant_id;
    assign req1_ready = (state_q == IDLE) && req1_valid &&  grant_id;
    assign rsp_valid  = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;

    logic_unit_core #(.WIDTH(WIDTH)) u_core (
        .op (op_q[2:0]),
        .a  (a_q),
        .b  (b_q),
        .y  (core_y)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    op_d    = grant_id ? req1_op : req0_op;
                    a_d     = grant_id ? req1_a  : req0_a;
                    b_d     = grant_id ? req1_b  : req0_b;
                    id_d    = grant_id;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d = core_y;
                rsp_id_d   = id_q;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    last_grant_d = rsp_id_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

`ifdef LOGIC_UNIT_SCHED_ZFLAG_EN
    logic zero_q, zero_d;

    always_comb begin
        zero_d = zero_q;
        if (state_q == EXEC) zero_d = (core_y == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) zero_q <= 1'b0;
        else        zero_q <= zero_d;
    end

    assign rsp_zero = zero_q;
`endif

endmodule

// File: tb/tb_logic_unit_sched.sv
// tb_logic_unit_sched: directed plus randomized checks of logic_unit_sched
// against a transaction-level reference model (truth-table result, round-robin
// grant tracked as "last served requester").
module tb_logic_unit_sched;
    import logic_unit_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [15:0] rsp_data;
`ifdef LOGIC_UNIT_SCHED_ZFLAG_EN
    logic        rsp_zero;
`endif

    int   total = 0;
    int   bad   = 0;
    logic model_last;

    always #5 clk = ~clk;

    logic_unit_sched #(.WIDTH(16), .OPW(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
`ifdef LOGIC_UNIT_SCHED_ZFLAG_EN
        .rsp_zero   (rsp_zero),
`endif
        .busy       (busy)
    );

    // Truth table per opcode, indexed by {a_bit, b_bit}.
    function automatic logic [15:0] ref_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [3:0]  tt;
        logic [15:0] y;
        case (op)
            3'd0: tt = 4'b1000;
            3'd1: tt = 4'b1110;
            3'd2: tt = 4'b0110;
            3'd3: tt = 4'b1001;
            3'd4: tt = 4'b0111;
            3'd5: tt = 4'b0001;
            3'd6: tt = 4'b0011;
            default: tt = 4'b1010;
        endcase
        for (int i = 0; i < 16; i++) y[i] = tt[{a[i], b[i]}];
        return y;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        req0_valid = 1'($urandom); req1_valid = 1'($urandom);
        req0_op = 3'($urandom); req1_op = 3'($urandom);
        req0_a = 16'($urandom); req0_b = 16'($urandom);
        req1_a = 16'($urandom); req1_b = 16'($urandom);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdy0"}, req0_ready, 0);
        chk({tag, "_rdy1"}, req1_ready, 0);
        chk({tag, "_rv"},   rsp_valid, 0);
        chk({tag, "_id"},   rsp_id, 0);
        chk({tag, "_data"}, rsp_data, 0);
        chk({tag, "_busy"}, busy, 0);
`ifdef LOGIC_UNIT_SCHED_ZFLAG_EN
        chk({tag, "_zero"}, rsp_zero, 0);
`endif
    endtask

    task automatic do_reset();
        req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        #1 rst_n = 0;
        #1 chk_all_zero("rst");
        @(posedge clk); #1 rst_n = 1;
        model_last = 1'b1;
    endtask

    // One full transaction. Called 1 time unit after a rising edge with the
    // DUT idle; returns 1 time unit after the response handshake edge.
    task automatic txn(input logic v0, input logic v1,
                       input logic [2:0] op0, input logic [15:0] a0, input logic [15:0] b0,
                       input logic [2:0] op1, input logic [15:0] a1, input logic [15:0] b1,
                       input int bp, input logic want_en, input logic [15:0] want);
        logic        gid;
        logic [15:0] exp;
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
        rsp_ready  = 1'($urandom);
        gid = (v0 && v1) ? ~model_last : v1;
        exp = gid ? ref_op(op1, a1, b1) : ref_op(op0, a0, b0);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_rv",   rsp_valid, 0);
        chk("idle_rdy0", req0_ready, v0 && !gid);
        chk("idle_rdy1", req1_ready, v1 && gid);
        @(posedge clk); #1;
        scramble();
        rsp_ready = 1'($urandom);
        @(negedge clk);
        chk("exec_busy", busy, 1);
        chk("exec_rv",   rsp_valid, 0);
        chk("exec_rdy",  {req0_ready, req1_ready}, 0);
        @(posedge clk); #1;
        for (int k = 0; k <= bp; k++) begin
            scramble();
            rsp_ready = (k == bp);
            @(negedge clk);
            chk("resp_rv",   rsp_valid, 1);
            chk("resp_id",   rsp_id, gid);
            chk("resp_data", rsp_data, exp);
            chk("resp_busy", busy, 1);
            chk("resp_rdy",  {req0_ready, req1_ready}, 0);
`ifdef LOGIC_UNIT_SCHED_ZFLAG_EN
            chk("resp_zero", rsp_zero, exp == 16'h0);
`endif
            if (want_en && k == 0) chk("want_data", rsp_data, want);
            @(posedge clk); #1;
        end
        model_last = gid;
    endtask

    initial begin
        logic [15:0] sweep_tbl [8];
        logic v0, v1;
        sweep_tbl = '{16'h05A0, 16'hAFF5, 16'hAA55, 16'h55AA,
                      16'hFA5F, 16'h500A, 16'h5A5A, 16'h0FF0};
        req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        req0_op = 0; req1_op = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        model_last = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_all_zero("por");
        rst_n = 1;

        // req0 alone
        txn(1, 0, OP_XNOR, 16'h1559, 16'h1551, 3'd0, 16'h0, 16'h0, 0, 1, 16'hFFF7);

        // tie after reset: req0 first, then req1
        do_reset();
        txn(1, 1, OP_XNOR, 16'h1559, 16'h1551, OP_AND, 16'hFF00, 16'h0F0F, 0, 1, 16'hFFF7);
        txn(1, 1, OP_XNOR, 16'h1559, 16'h1551, OP_AND, 16'hFF00, 16'h0F0F, 0, 1, 16'h0F00);

        // opcode sweep on req1
        for (int op = 0; op < 8; op++)
            txn(0, 1, 3'd0, 16'h0, 16'h0, 3'(op), 16'hA5A5, 16'h0FF0, 0, 1, sweep_tbl[op]);

        // backpressure
        txn(1, 0, OP_OR, 16'h1200, 16'h0034, 3'd0, 16'h0, 16'h0, 5, 1, 16'h1234);

        // fairness: both valid continuously, ids 0,1,0,1
        do_reset();
        for (int k = 0; k < 4; k++)
            txn(1, 1, 3'($urandom), 16'($urandom), 16'($urandom),
                3'($urandom), 16'($urandom), 16'($urandom), 0, 0, 16'h0);

        // reset during EXEC discards the transaction
        req0_valid = 0; req1_valid = 1; req1_op = OP_OR; req1_a = 16'h00FF; req1_b = 16'hFF00;
        rsp_ready = 1;
        @(posedge clk); #1;
        req1_valid = 0;
        #1 rst_n = 0;
        #1 chk_all_zero("midrst");
        @(posedge clk); #1 rst_n = 1;
        model_last = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_rv",   rsp_valid, 0);
            chk("post_rst_busy", busy, 0);
            @(posedge clk); #1;
        end
        // next tie goes to req0; zero result
        txn(1, 1, OP_XOR, 16'h1234, 16'h1234, OP_NOR, 16'h0, 16'h0, 0, 1, 16'h0000);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            v0 = 1'($urandom);
            v1 = v0 ? 1'($urandom) : 1'b1;
            txn(v0, v1, 3'($urandom), 16'($urandom), 16'($urandom),
                3'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 3), 0, 16'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
